// File: rtl/slave_mem_pkg.sv
// Shared types and helpers for the slave_mem_port storage endpoint.
package slave_mem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int CNT_W = 4;

  // True when the upper address bits (above addr_w) match the window base.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int          addr_w);
    logic [15:0] mask;
    mask = 16'hFFFF << addr_w;
    return ((addr ^ base) & mask) == 16'h0000;
  endfunction

endpackage

// File: rtl/slave_mem_if.sv
// Request/response bundle between slave_bb (master) and the memory port (slave).
interface slave_mem_if;
  logic [15:0] address_out;
  logic [7:0]  data_out;
  logic        mode_out;
  logic        valid_out;
  logic        ready;
  logic        sl_valid;
  logic [7:0]  sl_rdata;
  logic        err;
  logic        ovf;

  modport master (
    output address_out, data_out, mode_out, valid_out,
    input  ready, sl_valid, sl_rdata, err, ovf
  );

  modport slave (
    input  address_out, data_out, mode_out, valid_out,
    output ready, sl_valid, sl_rdata, err, ovf
  );
endinterface

// File: rtl/slave_mem_array.sv
// Single-port synchronous byte RAM with registered read data; no reset so it
// maps onto a block-RAM primitive and keeps its contents across rst.
module slave_mem_array #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**ADDR_W];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/slave_mem_port.sv
// Byte-wide target memory behind slave_bb with programmable read/write wait
// states, address-window decode, error pulse and sticky overflow flag.
module slave_mem_port
  import slave_mem_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] BASE_ADDR = 16'h1000,
  parameter int          READ_LAT  = 2,
  parameter int          WRITE_LAT = 1,
  parameter logic [7:0]  OOR_DATA  = 8'hFF
) (
  input logic        clk,
  input logic        rst,
  slave_mem_if.slave bus
);

  localparam logic [CNT_W-1:0] RD_CNT   = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT   = CNT_W'(WRITE_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              mode_q;
  logic              oor_q;
  logic              sl_valid_q;
  logic [7:0]        sl_rdata_q;
  logic              err_q;
  logic              ovf_q;

  logic              ready_s;
  logic              accept_s;
  logic              finish_s;
  logic              re_s;
  logic              we_s;
  logic [ADDR_W-1:0] idx_s;
  logic [7:0]        arr_rdata_s;

  // State register plus request latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      addr_q     <= {ADDR_W{1'b0}};
      data_q     <= 8'h00;
      mode_q     <= 1'b0;
      oor_q      <= 1'b0;
      sl_valid_q <= 1'b0;
      sl_rdata_q <= 8'h00;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        addr_q <= bus.address_out[ADDR_W-1:0];
        data_q <= bus.data_out;
        mode_q <= bus.mode_out;
        oor_q  <= !in_window(bus.address_out, BASE_ADDR, ADDR_W);
      end
      sl_valid_q <= finish_s && !mode_q;
      if (finish_s && !mode_q) begin
        sl_rdata_q <= oor_q ? OOR_DATA : arr_rdata_s;
      end
      err_q <= finish_s && oor_q;
      ovf_q <= ovf_q || (bus.valid_out && !ready_s);
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = WAIT;
          cnt_d   = bus.mode_out ? WR_CNT : RD_CNT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Handshake and array control. The array read is issued one edge before
  // the finish edge so its output register is part of the read latency.
  always_comb begin
    ready_s  = (state_q == IDLE);
    accept_s = bus.valid_out && ready_s;
    finish_s = (state_q == WAIT) && (cnt_q == CNT_ZERO);
    if (ready_s) begin
      idx_s = bus.address_out[ADDR_W-1:0];
      re_s  = accept_s && !bus.mode_out && (RD_CNT == CNT_ZERO);
    end else begin
      idx_s = addr_q;
      re_s  = !mode_q && (cnt_q == CNT_ONE);
    end
    we_s = finish_s && mode_q && !oor_q && !rst;
  end

  slave_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk_i   (clk),
    .we_i    (we_s),
    .re_i    (re_s),
    .idx_i   (idx_s),
    .wdata_i (data_q),
    .rdata_o (arr_rdata_s)
  );

  assign bus.ready    = ready_s;
  assign bus.sl_valid = sl_valid_q;
  assign bus.sl_rdata = sl_rdata_q;
  assign bus.err      = err_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_slave_mem_port.sv
// Directed bench for slave_mem_port: per-cycle comparison against a
// transaction-level model plus hand-computed spot checks.
module tb_slave_mem_port;

  logic clk;
  logic rst;
  slave_mem_if bus();

  slave_mem_port dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;
  bit done;

  // Model state: an op in flight finishes a fixed number of edges after acceptance.
  bit         m_ok;
  bit         m_busy;
  int         m_rem;
  bit         m_ready;
  bit         m_sl_valid;
  bit         m_err;
  bit         m_ovf;
  logic [7:0] m_rdata;
  bit         m_rdata_known;
  logic [7:0] m_mem [4096];
  bit         m_wr  [4096];
  bit         p_write;
  bit         p_in;
  int         p_idx;
  logic [7:0] p_data;

  always @(posedge clk) begin
    if (rst) begin
      m_ok <= 1'b1; m_busy <= 1'b0; m_rem <= 0; m_ready <= 1'b1;
      m_sl_valid <= 1'b0; m_err <= 1'b0; m_ovf <= 1'b0;
      m_rdata <= 8'h00; m_rdata_known <= 1'b1;
    end else begin
      m_sl_valid <= 1'b0;
      m_err      <= 1'b0;
      if (m_busy) begin
        if (bus.valid_out) m_ovf <= 1'b1;
        if (m_rem == 1) begin
          m_busy  <= 1'b0;
          m_ready <= 1'b1;
          if (p_write) begin
            if (p_in) begin
              m_mem[p_idx] <= p_data;
              m_wr[p_idx]  <= 1'b1;
            end else begin
              m_err <= 1'b1;
            end
          end else begin
            m_sl_valid <= 1'b1;
            if (p_in) begin
              m_rdata       <= m_mem[p_idx];
              m_rdata_known <= m_wr[p_idx];
            end else begin
              m_rdata       <= 8'hFF;
              m_rdata_known <= 1'b1;
              m_err         <= 1'b1;
            end
          end
        end else begin
          m_rem <= m_rem - 1;
        end
      end else if (bus.valid_out) begin
        m_busy  <= 1'b1;
        m_ready <= 1'b0;
        m_rem   <= bus.mode_out ? 1 : 2;
        p_write <= bus.mode_out;
        p_in    <= (bus.address_out[15:12] == 4'h1);
        p_idx   <= int'(bus.address_out[11:0]);
        p_data  <= bus.data_out;
      end
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk1("ready_timeout", bus.ready, 1'b1);
  endtask

  // Presents one request for a single edge; returns #1 after the accepting edge.
  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic m);
    bus.address_out = a;
    bus.data_out    = d;
    bus.mode_out    = m;
    bus.valid_out   = 1'b1;
    step();
    bus.valid_out   = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic exp_err);
    wait_ready();
    drive(a, d, 1'b1);
    chk1("wr_busy", bus.ready, 1'b0);
    step();
    chk1("wr_err", bus.err, exp_err);
    chk1("wr_no_resp", bus.sl_valid, 1'b0);
    chk1("wr_ready", bus.ready, 1'b1);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] exp_d, input logic exp_err);
    wait_ready();
    drive(a, 8'h00, 1'b0);
    chk1("rd_lat0", bus.sl_valid, 1'b0);
    step();
    chk1("rd_lat1", bus.sl_valid, 1'b0);
    step();
    chk1("rd_valid", bus.sl_valid, 1'b1);
    chk8("rd_data", bus.sl_rdata, exp_d);
    chk1("rd_err", bus.err, exp_err);
    step();
    chk1("rd_valid_pulse", bus.sl_valid, 1'b0);
    chk1("rd_err_pulse", bus.err, 1'b0);
    chk8("rd_data_hold", bus.sl_rdata, exp_d);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    done     = 1'b0;
    rst      = 1'b1;
    bus.address_out = 16'h0000;
    bus.data_out    = 8'h00;
    bus.mode_out    = 1'b0;
    bus.valid_out   = 1'b0;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          if (m_ok) begin
            chk1("m_ready", bus.ready, m_ready);
            chk1("m_sl_valid", bus.sl_valid, m_sl_valid);
            chk1("m_err", bus.err, m_err);
            chk1("m_ovf", bus.ovf, m_ovf);
            if (m_rdata_known) chk8("m_sl_rdata", bus.sl_rdata, m_rdata);
          end
        end
      end
      begin
        // 1: reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk1("rst_ready", bus.ready, 1'b1);
        chk1("rst_sl_valid", bus.sl_valid, 1'b0);
        chk8("rst_sl_rdata", bus.sl_rdata, 8'h00);
        chk1("rst_err", bus.err, 1'b0);
        chk1("rst_ovf", bus.ovf, 1'b0);
        // 2: write then read back
        do_write(16'h1234, 8'hAB, 1'b0);
        do_read(16'h1234, 8'hAB, 1'b0);
        // 3: out-of-window read and dropped write
        do_write(16'h1678, 8'h11, 1'b0);
        do_read(16'h5678, 8'hFF, 1'b1);
        do_write(16'h5678, 8'hEF, 1'b1);
        do_read(16'h1678, 8'h11, 1'b0);
        // 4: request while busy is dropped and sets ovf
        wait_ready();
        drive(16'h1234, 8'h00, 1'b0);
        bus.address_out = 16'h1678;
        bus.valid_out   = 1'b1;
        step();
        bus.valid_out   = 1'b0;
        chk1("ovf_set", bus.ovf, 1'b1);
        step();
        chk1("ovf_resp_valid", bus.sl_valid, 1'b1);
        chk8("ovf_resp_data", bus.sl_rdata, 8'hAB);
        step();
        chk1("ovf_no_second_a", bus.sl_valid, 1'b0);
        step();
        chk1("ovf_no_second_b", bus.sl_valid, 1'b0);
        chk1("ovf_sticky", bus.ovf, 1'b1);
        // 5: back-to-back write then read of the same address
        wait_ready();
        drive(16'h1234, 8'hC3, 1'b1);
        step();
        chk1("b2b_ready", bus.ready, 1'b1);
        drive(16'h1234, 8'h00, 1'b0);
        step();
        chk1("b2b_lat1", bus.sl_valid, 1'b0);
        step();
        chk1("b2b_valid", bus.sl_valid, 1'b1);
        chk8("b2b_data", bus.sl_rdata, 8'hC3);
        // 6: reset aborts a read in WAIT; reset on a write's finish edge drops it
        do_write(16'h1010, 8'h5A, 1'b0);
        wait_ready();
        drive(16'h1010, 8'h00, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("abort_idle", bus.ready, 1'b1);
        chk1("abort_ovf_clr", bus.ovf, 1'b0);
        for (int i = 0; i < 3; i++) begin
          chk1("abort_no_valid", bus.sl_valid, 1'b0);
          step();
        end
        wait_ready();
        drive(16'h1010, 8'h77, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("rstfin_err", bus.err, 1'b0);
        chk1("rstfin_valid", bus.sl_valid, 1'b0);
        do_read(16'h1010, 8'h5A, 1'b0);
        step();
        done = 1'b1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
